// File: rtl/image_encrypter_pkg.sv
// -----------------------------------------------------------------------------
// image_encrypter_pkg
//   Crypto constants and FSM encoding. The encrypter and the decrypter both
//   import this package, so the keystream and the state numbering always match.
//
//   Contents:
//     DEFAULT_SEED  LFSR seed used when the supplied key is zero
//     LFSR_TAPS     Galois feedback mask, XORed in when a 1 is shifted out
//     state_t       controller states IDLE / RUN / FLUSH / DONE
//     lfsr_step()   one right-shift step of the Galois LFSR
// -----------------------------------------------------------------------------
package image_encrypter_pkg;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Shift right by one. The bit that falls out of position 0 decides
    // whether the tap mask is folded back into the shifted state.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s,
                                              input logic [15:0] taps);
        return {1'b0, s[15:1]} ^ (s[0] ? taps : 16'h0000);
    endfunction

endpackage

// File: rtl/image_encrypter_if.sv
// -----------------------------------------------------------------------------
// image_encrypter_if
//   Groups the control handshake and both memory buses of image_encrypter.
//
//   Handshake semantics:
//     start/key  : start is a one-cycle request. It is accepted only when
//                  the block is idle, and key is sampled on that cycle. A
//                  start seen at any other time is dropped, and there is no
//                  acknowledge other than busy rising.
//     write_en   : qualifies write_addr/encrypted_data for exactly one byte
//                  per asserted cycle. There is no back-pressure; the RAM
//                  must accept every strobe.
//     read_addr  : feeds a synchronous-read ROM. plain_data belongs to the
//                  address that was presented one cycle earlier.
//
//   Signals (direction as seen from the encrypter, modport slave):
//     start, key, plain_data                       inputs
//     read_addr, write_addr, encrypted_data,
//     write_en, busy, done                         outputs
//     dbg_state, dbg_lfsr                          debug outputs (FSM, keystream)
// -----------------------------------------------------------------------------
interface image_encrypter_if
    import image_encrypter_pkg::*;
#(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              start;
    logic [15:0]       key;
    logic [ADDR_W-1:0] read_addr;
    logic [DATA_W-1:0] plain_data;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] encrypted_data;
    logic              write_en;
    logic              busy;
    logic              done;
    state_t            dbg_state;
    logic [15:0]       dbg_lfsr;

    // Encrypter side.
    modport slave (
        input  start, key, plain_data,
        output read_addr, write_addr, encrypted_data, write_en, busy, done,
        output dbg_state, dbg_lfsr
    );

    // Controller / memory side.
    modport master (
        output start, key, plain_data,
        input  read_addr, write_addr, encrypted_data, write_en, busy, done,
        input  dbg_state, dbg_lfsr
    );

endinterface

// File: rtl/image_encrypter_lfsr.sv
// -----------------------------------------------------------------------------
// keystream_lfsr
//   16-bit Galois LFSR that produces the cipher keystream. It is shared by
//   the encrypter and the decrypter, so both generate the same sequence from
//   the same seed.
//
//   Ports:
//     clk      in   clock
//     rst      in   synchronous, active-high. Returns the state to SEED_DEFAULT.
//     load     in   copy seed into the state (takes priority over advance)
//     seed     in   value loaded when load=1
//     advance  in   step the LFSR once
//     state    out  current LFSR state
// -----------------------------------------------------------------------------
module keystream_lfsr
    import image_encrypter_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = DEFAULT_SEED,
    parameter logic [15:0] TAPS         = LFSR_TAPS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED_DEFAULT;
        end else if (load) begin
            state <= seed;
        end else if (advance) begin
            state <= lfsr_step(state, TAPS);
        end
    end

endmodule

// File: rtl/image_encrypter.sv
// -----------------------------------------------------------------------------
// image_encrypter
//   Streams a whole image from an external synchronous ROM and XORs each byte
//   with the low byte of a keystream LFSR. The ciphertext is written to an
//   external RAM at one byte per cycle. The cipher is its own inverse, so the
//   same block with the same key also decrypts.
//
//   Pipeline (a = pixel address):
//     cycle t   : read_addr = a
//     cycle t+1 : ROM returns plain_data[a]; stage-1 holds a and its valid bit
//     cycle t+2 : write_en=1, write_addr=a, encrypted_data = plain ^ lfsr[7:0]
//   The LFSR steps once per written byte, so byte a always uses the seed
//   advanced a times.
//
//   Ports:
//     clk   in  pixel clock
//     rst   in  synchronous, active-high. Aborts any run in progress.
//     bus   image_encrypter_if.slave: start/key in, ROM read port,
//           RAM write port, busy/done status, debug state and LFSR
// -----------------------------------------------------------------------------
module image_encrypter
    import image_encrypter_pkg::*;
#(
    parameter int          ADDR_W       = 15,
    parameter int          DATA_W       = 8,
    parameter int          NUM_PIXELS   = 19200,
    parameter logic [15:0] SEED_DEFAULT = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    image_encrypter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state_q;
    state_t            state_n;
    logic              accept;

    logic [ADDR_W-1:0] rd_addr_q;
    logic              s1_valid_q;
    logic [ADDR_W-1:0] s1_addr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] enc_q;
    logic              wr_en_q;
    logic              busy_q;
    logic              done_q;

    logic [15:0]       seed;
    logic [15:0]       lfsr_state;

    // A start request only counts while idle. Once a run is accepted, start
    // and key are ignored until the block is back in IDLE.
    assign accept = (state_q == S_IDLE) && bus.start;

    // A zero key would lock the LFSR at zero, so it is replaced by the default seed.
    assign seed = (bus.key == 16'h0000) ? SEED_DEFAULT : bus.key;

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start) state_n = S_RUN;
            // Leave RUN once the last address has been presented.
            S_RUN:   if (rd_addr_q == LAST_ADDR) state_n = S_FLUSH;
            // Stage 1 empties one cycle before the last byte leaves the
            // output register. Entering DONE at that point puts the done
            // pulse right after the final write.
            S_FLUSH: if (!s1_valid_q) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register, address counter, pipeline and status outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_addr_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_addr_q  <= '0;
            wr_addr_q  <= '0;
            enc_q      <= '0;
            wr_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_n;

            // The read address saturates at the last pixel; it never wraps to 0.
            if (accept) begin
                rd_addr_q <= '0;
            end else if ((state_q == S_RUN) && (rd_addr_q != LAST_ADDR)) begin
                rd_addr_q <= rd_addr_q + 1'b1;
            end

            // Stage 1: the address whose ROM data arrives next cycle.
            s1_valid_q <= (state_q == S_RUN);
            s1_addr_q  <= rd_addr_q;

            // Stage 2: output registers. Address and data keep their last
            // values while no byte is being written.
            wr_en_q <= s1_valid_q;
            if (s1_valid_q) begin
                wr_addr_q <= s1_addr_q;
                enc_q     <= bus.plain_data ^ lfsr_state[DATA_W-1:0];
            end

            busy_q <= (state_n == S_RUN) || (state_n == S_FLUSH);
            done_q <= (state_n == S_DONE);
        end
    end

    // -------------------------------------------------------------------------
    // Keystream. It is seeded on the accepted start and steps once for every
    // byte written, so it changes on the same edge the write registers load.
    // -------------------------------------------------------------------------
    keystream_lfsr #(
        .SEED_DEFAULT (SEED_DEFAULT),
        .TAPS         (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .seed    (seed),
        .advance (s1_valid_q),
        .state   (lfsr_state)
    );

    assign bus.read_addr      = rd_addr_q;
    assign bus.write_addr     = wr_addr_q;
    assign bus.encrypted_data = enc_q;
    assign bus.write_en       = wr_en_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.dbg_state      = state_q;
    assign bus.dbg_lfsr       = lfsr_state;

endmodule

// File: tb/tb_image_encrypter.sv
// -----------------------------------------------------------------------------
// tb_image_encrypter
//   Scoreboard bench for image_encrypter. The driver computes the expected
//   ciphertext stream from a plain keystream model and queues it. A separate
//   monitor pops one entry per write_en cycle and compares address and data.
// -----------------------------------------------------------------------------
module tb_image_encrypter;
    import image_encrypter_pkg::*;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;
    localparam int N      = 19200;

    logic clk;
    logic rst;

    image_encrypter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    image_encrypter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .NUM_PIXELS   (N),
        .SEED_DEFAULT (16'hACE1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #20 clk = ~clk;

    // ---------------- memories and scoreboard ----------------
    logic [DATA_W-1:0]        rom  [N];
    logic [DATA_W-1:0]        ram  [N];
    logic [DATA_W-1:0]        orig [N];
    logic [ADDR_W+DATA_W-1:0] exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Synchronous-read ROM model.
    always @(posedge clk) begin
        if (int'(bus.read_addr) < N) bus.plain_data <= rom[bus.read_addr];
        else                         bus.plain_data <= '0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.write_en) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wr_unexpected: got write addr %0d data %0h, expected no write",
                         bus.write_addr, bus.encrypted_data);
            end else begin
                logic [ADDR_W+DATA_W-1:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.write_addr), 32'(e[ADDR_W+DATA_W-1:DATA_W]));
                check("wr_data", 32'(bus.encrypted_data), 32'(e[DATA_W-1:0]));
            end
            if (int'(bus.write_addr) < N) ram[bus.write_addr] = bus.encrypted_data;
        end
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_read_addr"},  32'(bus.read_addr), 32'd0);
        check({tag, "_write_addr"}, 32'(bus.write_addr), 32'd0);
        check({tag, "_enc_data"},   32'(bus.encrypted_data), 32'd0);
        check({tag, "_write_en"},   32'(bus.write_en), 32'd0);
        check({tag, "_busy"},       32'(bus.busy), 32'd0);
        check({tag, "_done"},       32'(bus.done), 32'd0);
        check({tag, "_state"},      32'(bus.dbg_state), 32'(S_IDLE));
    endtask

    // Run one image. The reference keystream starts at the key (or 16'hACE1
    // for a zero key) and steps by shifting right, XORing 16'hB400 in
    // whenever a 1 falls out. With expect_orig set, the expected bytes are
    // the original plaintext instead (round trip through the cipher).
    // abort_at >= 0: assert rst together with start (key abort_key) once
    // read_addr reaches abort_at.
    task automatic run_image(input logic [15:0] k, input int disturb_at, input int abort_at,
                             input logic [15:0] abort_key, input bit expect_orig);
        logic [15:0]       s;
        logic [DATA_W-1:0] d;
        int   inwin = 0, outside = 0, ra_over = 0, done_cyc = 0;
        logic busy_at_done = 1'b1;
        bit   aborted = 1'b0;

        s = (k == 16'h0000) ? 16'hACE1 : k;
        for (int a = 0; a < N; a++) begin
            d = expect_orig ? orig[a] : (rom[a] ^ s[7:0]);
            exp_q.push_back({ADDR_W'(a), d});
            s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
        end

        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = 16'($urandom);   // must not affect the run in progress

        for (int cyc = 1; cyc <= N + 8; cyc++) begin
            if (cyc == 1) begin
                check("first_read_addr", 32'(bus.read_addr), 32'd0);
                check("busy_on_start", 32'(bus.busy), 32'd1);
            end
            if (bus.write_en) begin
                if (cyc >= 3 && cyc <= N + 2) inwin++;
                else                          outside++;
            end
            if (int'(bus.read_addr) > N - 1) ra_over++;
            if (bus.done) begin
                done_cyc     = cyc;
                busy_at_done = bus.busy;
                break;
            end
            if (abort_at >= 0 && int'(bus.read_addr) == abort_at) begin
                rst       = 1'b1;
                bus.start = 1'b1;
                bus.key   = abort_key;
                @(posedge clk);
                exp_q.delete();
                @(negedge clk);
                check_idle_outputs("abort");
                check("abort_lfsr", 32'(bus.dbg_lfsr), 32'h0000ACE1);
                rst       = 1'b0;
                bus.start = 1'b0;
                aborted   = 1'b1;
                break;
            end
            bus.start = (cyc == disturb_at);
            if (cyc == disturb_at) bus.key = ~k;
            @(negedge clk);
        end

        if (!aborted) begin
            // done_cyc-1 cycles have passed since read_addr=0 was first presented.
            check("done_latency", 32'(done_cyc - 1), 32'(N + 2));
            check("busy_at_done", 32'(busy_at_done), 32'd0);
            check("write_count", 32'(inwin), 32'(N));
            check("write_outside_window", 32'(outside), 32'd0);
            check("read_addr_overrun", 32'(ra_over), 32'd0);
            @(negedge clk);
            check("done_width", 32'(bus.done), 32'd0);
            check("busy_after", 32'(bus.busy), 32'd0);
            check("hold_write_addr", 32'(bus.write_addr), 32'(N - 1));
            check("queue_drained", 32'(exp_q.size()), 32'd0);
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] k_main;
        int          rt_bad;

        rst       = 1'b1;
        bus.start = 1'b1;          // reset must win over start
        bus.key   = 16'h5555;
        for (int i = 0; i < N; i++) begin
            rom[i] = '0;
            ram[i] = 8'h5A;
        end
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_lfsr", 32'(bus.dbg_lfsr), 32'h0000ACE1);
        bus.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);

        // key 0001 on an all-zero image: ciphertext is the keystream itself.
        run_image(16'h0001, -1, 10, 16'h1234, 1'b0);
        check("k0001_byte0", 32'(ram[0]), 32'h01);
        check("k0001_byte1", 32'(ram[1]), 32'h00);
        check("k0001_byte2", 32'(ram[2]), 32'h00);

        // Zero key falls back to seed ACE1: FF ^ E1 = 1E.
        for (int i = 0; i < N; i++) rom[i] = 8'($urandom_range(0, 255));
        rom[0] = 8'hFF;
        ram[0] = 8'h5A;
        run_image(16'h0000, -1, 10, 16'h0000, 1'b0);
        check("k0000_byte0", 32'(ram[0]), 32'h1E);

        // Full random image, with a start and a new key thrown in at cycle 100.
        for (int i = 0; i < N; i++) begin
            rom[i]  = 8'($urandom_range(0, 255));
            orig[i] = rom[i];
        end
        k_main = 16'($urandom_range(1, 65535));
        run_image(k_main, 100, -1, 16'h0000, 1'b0);

        // Round trip: the ciphertext goes back through with the same key.
        for (int i = 0; i < N; i++) rom[i] = ram[i];
        run_image(k_main, -1, -1, 16'h0000, 1'b1);
        rt_bad = 0;
        for (int i = 0; i < N; i++) if (ram[i] !== orig[i]) rt_bad++;
        check("roundtrip_ram", 32'(rt_bad), 32'd0);

        // Abort at address 500, then restart from 0 with a fresh key.
        run_image(16'($urandom_range(1, 65535)), -1, 500, 16'hBEEF, 1'b0);
        run_image(16'($urandom_range(0, 65535)), -1, 600, 16'h0000, 1'b0);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
